// File: rtl/arb_pkg.sv
// Shared arbiter definitions: channel count, select width, FSM state type and
// the round-robin pick function reused by other arbiters.
// Ports: none (package).
package arb_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Searches ptr+1, ptr+2, ... (mod N_CH) and returns the first requesting
  // index. The mod is free because N_CH == 2**SEL_W and the sum wraps.
  // Returns ptr when nothing is requesting; callers qualify with |req.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_CH-1:0]  req,
                                                input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] res;
    logic             found;
    res   = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_data_mux.sv
// Combinational 4:1 channel mux for valid, last and DW-bit data.
// Ports:
//   i_sel    channel select
//   i_valid  per-channel valid
//   i_last   per-channel last flag
//   i_data   packed channel data, channel i at [i*DW +: DW]
//   o_valid  selected valid
//   o_last   selected last
//   o_data   selected data
module arb_data_mux
  import arb_pkg::*;
#(
  parameter int DW = 2
) (
  input  logic [SEL_W-1:0]   i_sel,
  input  logic [N_CH-1:0]    i_valid,
  input  logic [N_CH-1:0]    i_last,
  input  logic [N_CH*DW-1:0] i_data,
  output logic               o_valid,
  output logic               o_last,
  output logic [DW-1:0]      o_data
);

  assign o_valid = i_valid[i_sel];
  assign o_last  = i_last[i_sel];
  assign o_data  = i_data[i_sel*DW +: DW];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 data mux. One channel is
// granted at a time and keeps the grant until its last beat transfers; a
// one-cycle IDLE bubble always separates consecutive grants.
// Optional feature macro: ARB_TIMEOUT_EN -- revokes a grant after TIMEOUT_CYC
// consecutive cycles without valid on the granted channel.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/last/data   per-channel source beats
//   req_ready             per-channel accept (only the granted channel)
//   out_valid/last/data   downstream beat
//   out_ready             downstream accept
//   sel                   registered mux select
//   grant                 registered one-hot grant, 0 when idle
//   timeout               one-cycle pulse on forced revoke
//
// state | meaning
// IDLE  | no owner; arbitrate among req_valid using ptr order
// GRANT | channel sel owns the output until a last beat transfers
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int DW          = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    req_valid,
  input  logic [N_CH-1:0]    req_last,
  input  logic [N_CH*DW-1:0] req_data,
  output logic [N_CH-1:0]    req_ready,
  output logic               out_valid,
  output logic               out_last,
  output logic [DW-1:0]      out_data,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [N_CH-1:0]    grant,
  output logic               timeout
);

  arb_state_t       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [N_CH-1:0]  r_grant;
  logic             r_timeout;

  logic             w_active;
  logic             w_mux_valid;
  logic             w_mux_last;
  logic [DW-1:0]    w_mux_data;
  logic [SEL_W-1:0] w_pick;
  logic             w_done;
  logic             w_expire;

  arb_data_mux #(.DW(DW)) u_mux (
    .i_sel   (r_sel),
    .i_valid (req_valid),
    .i_last  (req_last),
    .i_data  (req_data),
    .o_valid (w_mux_valid),
    .o_last  (w_mux_last),
    .o_data  (w_mux_data)
  );

  // Reset is synchronous, so the handshake is also gated by rst_n to keep any
  // beat from transferring during a reset cycle.
  assign w_active  = rst_n && (r_state == ST_GRANT);
  assign w_pick    = rr_pick(req_valid, r_ptr);
  assign out_valid = w_active && w_mux_valid;
  assign out_last  = w_active && w_mux_last;
  assign out_data  = w_active ? w_mux_data : '0;
  assign w_done    = out_valid && out_ready && out_last;

  always_comb begin
    req_ready = '0;
    if (w_active) req_ready[r_sel] = out_ready;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int               CNT_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] STALL_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_stall;

  // Fires on the TIMEOUT_CYC-th consecutive stall cycle of the owner.
  assign w_expire = (r_state == ST_GRANT) && !req_valid[r_sel] && (r_stall == STALL_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (r_state != ST_GRANT || req_valid[r_sel]) begin
      r_stall <= '0;
    end else if (r_stall != STALL_MAX) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_ptr     <= SEL_W'(N_CH - 1);
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_state <= ST_GRANT;
            r_sel   <= w_pick;
            r_grant <= {{(N_CH-1){1'b0}}, 1'b1} << w_pick;
          end
        end
        ST_GRANT: begin
          if (w_done || w_expire) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_ptr     <= r_sel;
            r_timeout <= w_expire;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel     = r_sel;
  assign grant   = r_grant;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  localparam int DW = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [7:0] req_data;
  logic [3:0] req_ready;
  logic       out_valid;
  logic       out_last;
  logic [1:0] out_data;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  rr_mux_arbiter #(.DW(DW), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic l, input logic [1:0] d);
    req_valid[ch]         = v;
    req_last[ch]          = l;
    req_data[ch*2 +: 2]   = d;
  endtask

  task automatic do_reset();
    tick();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Source protocol: a pending (valid, not ready) beat must be held unchanged.
  logic [3:0] p_valid, p_ready, p_last;
  logic [7:0] p_data;
  logic       p_rstn = 1'b0;
  always @(posedge clk) begin
    if (rst_n && p_rstn) begin
      for (int i = 0; i < 4; i++) begin
        if (p_valid[i] && !p_ready[i]) begin
          n_chk++;
          if (!req_valid[i] || req_last[i] !== p_last[i] || req_data[i*2 +: 2] !== p_data[i*2 +: 2]) begin
            n_fail++;
            $display("FAIL src_hold ch%0d: valid %b data %0h, required held valid data %0h", i, req_valid[i], req_data[i*2 +: 2], p_data[i*2 +: 2]);
          end
        end
      end
    end
    p_valid <= req_valid;
    p_ready <= req_ready;
    p_last  <= req_last;
    p_data  <= req_data;
    p_rstn  <= rst_n;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       ordy;
    logic [3:0] g;
    logic [1:0] s;
    logic [3:0] rdy;
    logic       ov;
    logic       ol;
    logic [1:0] od;
  } vec_t;

  vec_t tbl[10];

  // Random-phase reference model: integer owner (-1 when idle) and the
  // channel that owned last; arbitration is a plain modular scan.
  int         m_owner, m_prev, m_sel, m_stall;
  logic       m_to;
  logic [3:0] src_v, src_l, acc;
  logic [1:0] src_d[4];
  logic [3:0] eg, erdy;
  logic       eov;

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b0;

    tbl[0] = '{4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0};
    tbl[1] = '{4'hF, 4'hF, 1'b1, 4'h1, 2'd0, 4'h1, 1'b1, 1'b1, 2'd0};
    tbl[2] = '{4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 4'h0, 1'b0, 1'b0, 2'd0};
    tbl[3] = '{4'hF, 4'hF, 1'b1, 4'h2, 2'd1, 4'h2, 1'b1, 1'b1, 2'd1};
    tbl[4] = '{4'hF, 4'hF, 1'b1, 4'h0, 2'd1, 4'h0, 1'b0, 1'b0, 2'd0};
    tbl[5] = '{4'hF, 4'hF, 1'b1, 4'h4, 2'd2, 4'h4, 1'b1, 1'b1, 2'd2};
    tbl[6] = '{4'hF, 4'hF, 1'b1, 4'h0, 2'd2, 4'h0, 1'b0, 1'b0, 2'd0};
    tbl[7] = '{4'hF, 4'hF, 1'b1, 4'h8, 2'd3, 4'h8, 1'b1, 1'b1, 2'd3};
    tbl[8] = '{4'hF, 4'hF, 1'b1, 4'h0, 2'd3, 4'h0, 1'b0, 1'b0, 2'd0};
    tbl[9] = '{4'hF, 4'hF, 1'b1, 4'h1, 2'd0, 4'h1, 1'b1, 1'b1, 2'd0};

    // Reset with all channels requesting.
    tick();
    rst_n = 1'b0; req_valid = 4'hF; req_last = 4'hF; out_ready = 1'b1;
    tick(); #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_ovalid", 32'(out_valid), 32'h0);
    tick(); #2;
    chk("rst2_ready", 32'(req_ready), 32'h0);
    tick();
    rst_n = 1'b1; #2;
    chk("rel_idle_grant", 32'(grant), 32'h0);
    tick(); #2;
    chk("rel_first_grant", 32'(grant), 32'h1);
    chk("rel_first_ready", 32'(req_ready), 32'h1);

    // Fairness table: 1-beat packets from all four channels.
    do_reset();
    req_data = {2'd3, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].v;
      req_last  = tbl[i].l;
      out_ready = tbl[i].ordy;
      #2;
      chk($sformatf("fair%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("fair%0d_sel", i), 32'(sel), 32'(tbl[i].s));
      chk($sformatf("fair%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("fair%0d_ovalid", i), 32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("fair%0d_olast", i), 32'(out_last), 32'(tbl[i].ol));
        chk($sformatf("fair%0d_odata", i), 32'(out_data), 32'(tbl[i].od));
      end
      tick();
    end

    // Packet hold: ch2 3-beat packet, ch1 arrives mid-packet.
    do_reset();
    out_ready = 1'b1;
    set_ch(2, 1'b1, 1'b0, 2'd1);
    #2; chk("hold_idle", 32'(grant), 32'h0);
    tick(); #2;
    chk("hold_b1_grant", 32'(grant), 32'h4);
    chk("hold_b1_data", 32'(out_data), 32'd1);
    chk("hold_b1_ready", 32'(req_ready), 32'h4);
    tick();
    set_ch(2, 1'b1, 1'b0, 2'd2);
    set_ch(1, 1'b1, 1'b1, 2'd3);
    #2;
    chk("hold_b2_grant", 32'(grant), 32'h4);
    chk("hold_b2_data", 32'(out_data), 32'd2);
    chk("hold_b2_ready", 32'(req_ready), 32'h4);
    tick();
    set_ch(2, 1'b1, 1'b1, 2'd0);
    #2;
    chk("hold_b3_grant", 32'(grant), 32'h4);
    chk("hold_b3_data", 32'(out_data), 32'd0);
    chk("hold_b3_last", 32'(out_last), 32'd1);
    tick();
    set_ch(2, 1'b0, 1'b0, 2'd0);
    #2;
    chk("hold_bubble_grant", 32'(grant), 32'h0);
    chk("hold_bubble_ovalid", 32'(out_valid), 32'h0);
    tick(); #2;
    chk("hold_ch1_grant", 32'(grant), 32'h2);
    chk("hold_ch1_data", 32'(out_data), 32'd3);
    tick();

    // Backpressure on ch3.
    do_reset();
    set_ch(3, 1'b1, 1'b1, 2'd2);
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("bp%0d_grant", i), 32'(grant), 32'h8);
      chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'h0);
      chk($sformatf("bp%0d_ovalid", i), 32'(out_valid), 32'h1);
      chk($sformatf("bp%0d_data", i), 32'(out_data), 32'd2);
      tick();
    end
    out_ready = 1'b1;
    #2; chk("bp_go_ready", 32'(req_ready), 32'h8);
    tick(); #2;
    chk("bp_after_grant", 32'(grant), 32'h0);
    tick();

    // Reset mid-packet.
    do_reset();
    out_ready = 1'b1;
    set_ch(1, 1'b1, 1'b0, 2'd1);
    tick(); #2;
    chk("rmid_b1_grant", 32'(grant), 32'h2);
    tick();
    set_ch(1, 1'b1, 1'b0, 2'd2);
    rst_n = 1'b0;
    #2;
    chk("rmid_rst_ready", 32'(req_ready), 32'h0);
    chk("rmid_rst_ovalid", 32'(out_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    set_ch(0, 1'b1, 1'b1, 2'd3);
    set_ch(1, 1'b1, 1'b1, 2'd1);
    #2;
    chk("rmid_post_grant", 32'(grant), 32'h0);
    tick(); #2;
    chk("rmid_ch0_wins", 32'(grant), 32'h1);
    chk("rmid_ch0_data", 32'(out_data), 32'd3);
    tick();

    // Stall on granted channel.
    do_reset();
    out_ready = 1'b1;
    set_ch(1, 1'b1, 1'b0, 2'd1);
    tick(); #2;
    chk("stall_grant", 32'(grant), 32'h2);
    tick();
    set_ch(1, 1'b0, 1'b0, 2'd0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      #2;
      chk($sformatf("to_stall%0d_grant", i), 32'(grant), 32'h2);
      chk($sformatf("to_stall%0d_pulse", i), 32'(timeout), 32'h0);
      tick();
    end
    set_ch(1, 1'b1, 1'b1, 2'd1);
    set_ch(2, 1'b1, 1'b1, 2'd2);
    #2;
    chk("to_pulse", 32'(timeout), 32'h1);
    chk("to_revoked", 32'(grant), 32'h0);
    tick(); #2;
    chk("to_next_ch2", 32'(grant), 32'h4);
    chk("to_pulse_end", 32'(timeout), 32'h0);
    tick();
`else
    for (int i = 0; i < TO + 4; i++) begin
      #2;
      chk($sformatf("hold%0d_grant", i), 32'(grant), 32'h2);
      chk($sformatf("hold%0d_timeout", i), 32'(timeout), 32'h0);
      tick();
    end
    set_ch(1, 1'b1, 1'b1, 2'd1);
    #2; chk("hold_resume_ready", 32'(req_ready), 32'h2);
    tick(); #2;
    chk("hold_resume_idle", 32'(grant), 32'h0);
    tick();
`endif

    // Random traffic against the reference model.
    do_reset();
    m_owner = -1; m_prev = 3; m_sel = 0; m_stall = 0; m_to = 1'b0;
    src_v = '0; src_l = '0; acc = '0;
    for (int i = 0; i < 4; i++) src_d[i] = 2'd0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!src_v[i] || acc[i]) begin
          src_v[i] = ($urandom_range(0, 1) == 1);
          src_l[i] = ($urandom_range(0, 2) == 0);
          src_d[i] = 2'($urandom_range(0, 3));
        end
        set_ch(i, src_v[i], src_l[i], src_d[i]);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #2;
      eg   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      erdy = (m_owner >= 0 && out_ready) ? (4'b0001 << m_owner) : 4'b0000;
      eov  = (m_owner >= 0) ? src_v[m_owner] : 1'b0;
      chk($sformatf("rnd%0d_grant", c), 32'(grant), 32'(eg));
      chk($sformatf("rnd%0d_sel", c), 32'(sel), 32'(m_sel));
      chk($sformatf("rnd%0d_ready", c), 32'(req_ready), 32'(erdy));
      chk($sformatf("rnd%0d_ovalid", c), 32'(out_valid), 32'(eov));
      chk($sformatf("rnd%0d_timeout", c), 32'(timeout), 32'(m_to));
      if (eov) begin
        chk($sformatf("rnd%0d_data", c), 32'(out_data), 32'(src_d[m_owner]));
        chk($sformatf("rnd%0d_last", c), 32'(out_last), 32'(src_l[m_owner]));
      end
      acc  = '0;
      m_to = 1'b0;
      if (m_owner < 0) begin
        if (|src_v) begin
          for (int k = 1; k <= 4; k++) begin
            if (m_owner < 0 && src_v[(m_prev + k) % 4]) m_owner = (m_prev + k) % 4;
          end
          m_sel   = m_owner;
          m_stall = 0;
        end
      end else if (src_v[m_owner] && out_ready) begin
        acc[m_owner] = 1'b1;
        m_stall      = 0;
        if (src_l[m_owner]) begin
          m_prev  = m_owner;
          m_owner = -1;
        end
      end else if (!src_v[m_owner]) begin
`ifdef ARB_TIMEOUT_EN
        m_stall++;
        if (m_stall == TO) begin
          m_prev  = m_owner;
          m_owner = -1;
          m_to    = 1'b1;
        end
`endif
      end else begin
        m_stall = 0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
